pwm_multi: RTL
==============

# pwm_multi

Multi-channel PWM generator: the parametrised successor of the single-channel, free-running PWM. N channels share one period counter with a programmable prescaler, a programmable period, and edge- or center-aligned counting. Period, mode and duty values are double-buffered so that new settings take effect only at a period boundary. The block sits between the register/control logic and the pad drivers (motor, LED or servo outputs), and drives registered, glitch-free outputs.

## Interface
- R, 8, counter/period/duty width
- N, 4, channel count
- PW, 8, prescaler width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset; all state returns to reset values immediately
- en  in  1  run enable; 0 holds the counter and forces outputs low
- mode  in  1  0 = edge-aligned, 1 = center-aligned; staged by load
- presc  in  PW  prescaler; one counter tick every presc+1 clocks; live, not staged
- period  in  R  period value P; staged by load
- duty  in  N*R  duty values; channel i uses bits [i*R +: R]; staged by load
- load  in  1  single-cycle strobe; captures mode/period/duty into the staging registers
- out  out  N  PWM outputs, registered
- sync  out  1  single-cycle pulse at the start of each period
- pending  out  1  staged values are waiting for a boundary

## Operation
- Reset values: pc=0, cnt=0, dir=up, period_s={R{1}}, duty_s=0, mode_s=0, staging=0, pending=0, out=0, sync=0.
- Prescaler:
  - pc increments every clock while en=1.
  - tick=1 when pc>=presc; pc then returns to 0.
  - presc=0 gives a tick every clock.
  - Using >= means lowering presc mid-count causes no long wrap.
- Edge mode (mode_s=0):
  - On each tick, cnt steps 0,1,…,P, then wraps to 0.
  - Period is P+1 ticks.
  - Boundary = tick && cnt==P.
- Center mode (mode_s=1):
  - cnt counts up 0…P, then down P-1…1, then back to 0. dir flips at P and at 0.
  - Period is 2P ticks.
  - Boundary = tick && dir=down && cnt==1.
  - P=0: cnt stays 0 and every tick is a boundary.
- Compare: out[i] is set to (cnt < duty_s[i]) each clock, registered.
  - duty_s=0 gives constant low.
  - Edge mode: duty_s>P gives constant high; otherwise high for duty_s ticks.
  - Center mode: high for 2*duty_s-1 ticks for 1≤duty_s≤P, symmetric about cnt=0.
- Staging:
  - load=1 copies mode/period/duty into staging and sets pending. A later load before the boundary overwrites staging.
  - At a boundary with pending=1: shadow ← staging, pending ← 0, cnt ← 0, dir ← up.
  - Shadow registers are never written outside a boundary while en=1.
- Simultaneous load and boundary in the same cycle: the boundary transfers the old staging contents, then the new load writes staging. pending stays 1 and the new values apply at the next boundary.
- Disable (en=0):
  - pc, cnt and dir are held at 0/up; out=0, sync=0.
  - Any pending staging transfers to shadow on the next clock, and pending clears.
  - On en rising, counting restarts from cnt=0 and sync pulses on the first tick.
- sync is registered and asserts for one clock in the cycle after cnt enters 0 at a period start, including the first tick after enable.
- Arithmetic: all compares are unsigned R-bit. cnt never exceeds period_s, and no carry is needed.

## Timing
- out latency: 1 clock after the cnt value it reflects.
- load to effect: takes effect at the first boundary after load. Worst case is one full period plus one clock.
- en fall: out=0 on the next clock edge.
- rst mid-period: outputs go low asynchronously, and staged/shadow contents are lost.
- The prescaler applies only to cnt; staging and sync are evaluated every clock.

## Test plan
- Reset, then load P=9, mode=0, duty={0,3,9,12}, presc=0, en=1:
  - every 10 clocks, out[0]=0, out[1] high 3 clocks, out[2] high 9 clocks, out[3] constant high.
  - sync pulses every 10 clocks.
- presc=2 with the same settings: period 30 clocks; out[1] high 9 clocks.
- Center mode, load P=8, duty[0]=3, presc=0: period 16 clocks; out[0] high 5 clocks, centered on cnt=0.
- Mid-period load of duty[0]=5 from 3 (edge, P=9):
  - the current period keeps 3 and pending=1;
  - the next period shows 5 and pending=0.
  - Repeat with load coincident with the boundary: 5 appears one period later.
- Assert rst while out=1 mid-period: out=0 and pending=0 immediately. After release with en=1 and no load: P=255, duty=0, out stays low.
- Drop en mid-period with a pending load: out=0 on the next clock and pending clears. On re-enable, the new values apply from cnt=0 and sync pulses.

Source files
------------

// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shared prescaled counter,
// edge/center alignment and double-buffered period/mode/duty.
module pwm_multi #(
  parameter int R  = 8,
  parameter int N  = 4,
  parameter int PW = 8
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic           i_mode,
  input  logic [PW-1:0]  i_presc,
  input  logic [R-1:0]   i_period,
  input  logic [N*R-1:0] i_duty,
  input  logic           i_load,
  output logic [N-1:0]   o_out,
  output logic           o_sync,
  output logic           o_pending
);

  localparam logic [R-1:0] ONE = R'(1);

  logic [PW-1:0]  r_pc;
  logic [R-1:0]   r_cnt;
  logic           r_dir;
  logic [R-1:0]   r_period_s;
  logic [N*R-1:0] r_duty_s;
  logic           r_mode_s;
  logic [R-1:0]   r_period_t;
  logic [N*R-1:0] r_duty_t;
  logic           r_mode_t;
  logic           r_pending;
  logic [N-1:0]   r_out;
  logic           r_sync;

  logic           w_tick;
  logic           w_wrap;
  logic           w_boundary;
  logic           w_xfer;
  logic [R-1:0]   w_cnt_nxt;
  logic           w_dir_nxt;
  logic [N-1:0]   w_cmp;

  // >= rather than == so a lowered prescale never forces a full wrap of r_pc
  assign w_tick     = i_en && (r_pc >= i_presc);
  assign w_boundary = w_tick && w_wrap;
  assign w_xfer     = r_pending && (w_boundary || !i_en);

  always_comb begin
    w_wrap    = 1'b0;
    w_cnt_nxt = r_cnt + ONE;
    w_dir_nxt = r_dir;
    if (!r_mode_s) begin
      if (r_cnt >= r_period_s) w_wrap = 1'b1;
    end else if (!r_dir) begin
      if (r_cnt >= r_period_s) begin
        // P of 0 or 1 has no down-count leg: the peak is also the period end
        if (r_period_s <= ONE) begin
          w_wrap = 1'b1;
        end else begin
          w_dir_nxt = 1'b1;
          w_cnt_nxt = r_cnt - ONE;
        end
      end
    end else begin
      w_cnt_nxt = r_cnt - ONE;
      if (r_cnt <= ONE) w_wrap = 1'b1;
    end
    if (w_wrap) begin
      w_cnt_nxt = '0;
      w_dir_nxt = 1'b0;
    end
  end

  always_comb begin
    w_cmp = '0;
    for (int i = 0; i < N; i++) begin
      w_cmp[i] = r_cnt < r_duty_s[i*R +: R];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pc       <= '0;
      r_cnt      <= '0;
      r_dir      <= 1'b0;
      r_period_s <= '1;
      r_duty_s   <= '0;
      r_mode_s   <= 1'b0;
      r_period_t <= '0;
      r_duty_t   <= '0;
      r_mode_t   <= 1'b0;
      r_pending  <= 1'b0;
      r_out      <= '0;
      r_sync     <= 1'b0;
    end else begin
      if (!i_en || w_tick) r_pc <= '0;
      else                 r_pc <= r_pc + 1'b1;

      if (!i_en || w_xfer) begin
        r_cnt <= '0;
        r_dir <= 1'b0;
      end else if (w_tick) begin
        r_cnt <= w_cnt_nxt;
        r_dir <= w_dir_nxt;
      end

      if (w_xfer) begin
        r_period_s <= r_period_t;
        r_duty_s   <= r_duty_t;
        r_mode_s   <= r_mode_t;
      end

      // a load in the transfer cycle refills staging after the old contents moved
      if (i_load) begin
        r_period_t <= i_period;
        r_duty_t   <= i_duty;
        r_mode_t   <= i_mode;
        r_pending  <= 1'b1;
      end else if (w_xfer) begin
        r_pending  <= 1'b0;
      end

      r_out  <= i_en ? w_cmp : '0;
      r_sync <= w_tick && (r_cnt == '0) && !r_dir;
    end
  end

  assign o_out     = r_out;
  assign o_sync    = r_sync;
  assign o_pending = r_pending;

endmodule
